// File: rtl/dual_port_ram.sv
// ---------------------------------------------------------------------------
// dual_port_ram
//
// Simple dual-port synchronous RAM on one clock: one write port and one
// read port. Every rising edge (outside reset) writes din to write_addr.
// The word at read_addr appears on dout one edge later. A write and a read
// to the same address on the same edge are write-first: dout takes the new
// din, not the old contents.
//
// Parameters
//   WIDTH   address width in bits; depth is 2**WIDTH words
//   LENGTH  data word width in bits
//
// Ports
//   clk         system clock, rising-edge active
//   rst         synchronous reset, active-high. Clears dout and blocks
//               writes; memory contents are kept.
//   write_addr  write address
//   read_addr   read address
//   din         write data
//   dout        registered read data
// ---------------------------------------------------------------------------
module dual_port_ram #(
    parameter int WIDTH  = 13,
    parameter int LENGTH = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  write_addr,
    input  logic [WIDTH-1:0]  read_addr,
    input  logic [LENGTH-1:0] din,
    output logic [LENGTH-1:0] dout
);

    localparam int DEPTH = 1 << WIDTH;

    logic [LENGTH-1:0] mem [DEPTH];
    logic [LENGTH-1:0] read_word;
    logic              same_addr;

    // Write port. This block has no reset so the array still infers as
    // block RAM. rst only gates the write enable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem[write_addr] <= din;
        end
    end

    // Write-first bypass. A read that hits the address being written this
    // edge takes din directly. The array's old word is stale in that case.
    assign same_addr = (read_addr == write_addr);
    assign read_word = same_addr ? din : mem[read_addr];

    // Output register: one cycle of read latency. Reset clears it to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
        end else begin
            dout <= read_word;
        end
    end

endmodule

// File: tb/tb_dual_port_ram.sv
// ---------------------------------------------------------------------------
// tb_dual_port_ram
//
// Self-checking bench for dual_port_ram. A behavioural model holds the
// memory as a plain array and predicts dout from these rules:
//   - reset gives 0 and blocks the write;
//   - a same-address read returns the new data;
//   - any other read returns the stored word.
// Each scenario task drives edges and compares dout inline.
// ---------------------------------------------------------------------------
module tb_dual_port_ram;

    localparam int WIDTH  = 13;
    localparam int LENGTH = 12;
    localparam int DEPTH  = 1 << WIDTH;

    logic              clk;
    logic              rst;
    logic [WIDTH-1:0]  write_addr;
    logic [WIDTH-1:0]  read_addr;
    logic [LENGTH-1:0] din;
    logic [LENGTH-1:0] dout;

    int checks_total;
    int checks_passed;

    // Reference model state
    logic [LENGTH-1:0] model_mem  [DEPTH];
    bit                model_seen [DEPTH];
    logic [WIDTH-1:0]  written_q  [$];
    logic [LENGTH-1:0] exp_dout;

    dual_port_ram #(
        .WIDTH  (WIDTH),
        .LENGTH (LENGTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .write_addr (write_addr),
        .read_addr  (read_addr),
        .din        (din),
        .dout       (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one set of inputs for one rising edge and advance the model.
    // Returns 1 ns after the edge, when dout is stable.
    task automatic tick(input logic r, input int wa, input int ra, input int d);
        logic [WIDTH-1:0]  wa_v;
        logic [WIDTH-1:0]  ra_v;
        logic [LENGTH-1:0] d_v;
        wa_v = WIDTH'(wa);
        ra_v = WIDTH'(ra);
        d_v  = LENGTH'(d);
        rst        = r;
        write_addr = wa_v;
        read_addr  = ra_v;
        din        = d_v;
        if (r) begin
            exp_dout = '0;
        end else begin
            if (ra_v == wa_v) exp_dout = d_v;
            else              exp_dout = model_mem[ra_v];
            model_mem[wa_v] = d_v;
            if (!model_seen[wa_v]) begin
                model_seen[wa_v] = 1'b1;
                written_q.push_back(wa_v);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(1'b1, 0, 0, 1);
        checks_total++;
        if (dout !== 12'h000) $display("FAIL reset_edge1 dout=%h expected=%h", dout, 12'h000);
        else checks_passed++;
        tick(1'b1, 0, 0, 1);
        checks_total++;
        if (dout !== 12'h000) $display("FAIL reset_edge2 dout=%h expected=%h", dout, 12'h000);
        else checks_passed++;
        // Store a known word at addr 0, then reset again while a write to addr 0 is presented
        tick(1'b0, 0, 0, 12'h3C3);
        checks_total++;
        if (dout !== exp_dout) $display("FAIL reset_prep dout=%h expected=%h", dout, exp_dout);
        else checks_passed++;
        tick(1'b1, 0, 0, 1);
        tick(1'b1, 0, 0, 1);
        checks_total++;
        if (dout !== 12'h000) $display("FAIL reset_hold dout=%h expected=%h", dout, 12'h000);
        else checks_passed++;
        // mem[0] must still hold 0x3C3; the reset-time writes were dropped
        tick(1'b0, 1, 0, 12'h111);
        checks_total++;
        if (dout !== 12'h3C3) $display("FAIL reset_no_write dout=%h expected=%h", dout, 12'h3C3);
        else checks_passed++;
    endtask

    task automatic test_same_addr();
        tick(1'b0, 0, 0, 1);
        checks_total++;
        if (dout !== 12'd1) $display("FAIL same_addr_first dout=%h expected=%h", dout, 12'd1);
        else checks_passed++;
        for (int i = 0; i < 100; i++) begin
            tick(1'b0, 0, 0, 1);
            checks_total++;
            if (dout !== exp_dout) $display("FAIL same_addr_stable cyc=%0d dout=%h expected=%h", i, dout, exp_dout);
            else checks_passed++;
        end
        tick(1'b0, 0, 0, 10);
        checks_total++;
        if (dout !== 12'd10) $display("FAIL bypass_change dout=%h expected=%h", dout, 12'd10);
        else checks_passed++;
    endtask

    task automatic test_independent();
        tick(1'b0, 100, 0, 12'h5A5);
        checks_total++;
        if (dout !== 12'd10) $display("FAIL indep_w100 dout=%h expected=%h", dout, 12'd10);
        else checks_passed++;
        tick(1'b0, 8191, 0, 12'h123);
        checks_total++;
        if (dout !== 12'd10) $display("FAIL indep_w8191 dout=%h expected=%h", dout, 12'd10);
        else checks_passed++;
        tick(1'b0, 200, 100, 12'h000);
        checks_total++;
        if (dout !== 12'h5A5) $display("FAIL indep_r100 dout=%h expected=%h", dout, 12'h5A5);
        else checks_passed++;
        tick(1'b0, 200, 8191, 12'h000);
        checks_total++;
        if (dout !== 12'h123) $display("FAIL indep_r8191 dout=%h expected=%h", dout, 12'h123);
        else checks_passed++;
    endtask

    task automatic test_reset_mid();
        tick(1'b0, 300, 100, 12'h0AA);
        checks_total++;
        if (dout !== 12'h5A5) $display("FAIL mid_before dout=%h expected=%h", dout, 12'h5A5);
        else checks_passed++;
        tick(1'b1, 100, 100, 12'hFFF);
        checks_total++;
        if (dout !== 12'h000) $display("FAIL mid_reset dout=%h expected=%h", dout, 12'h000);
        else checks_passed++;
        tick(1'b0, 300, 100, 12'h0AA);
        checks_total++;
        if (dout !== 12'h5A5) $display("FAIL mid_after dout=%h expected=%h", dout, 12'h5A5);
        else checks_passed++;
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < 16; a++) begin
            tick(1'b0, a, a, a);
            checks_total++;
            if (dout !== exp_dout) $display("FAIL sweep_write a=%0d dout=%h expected=%h", a, dout, exp_dout);
            else checks_passed++;
        end
        for (int a = 0; a < 16; a++) begin
            tick(1'b0, 1000, a, int'($urandom_range(0, 4095)));
            checks_total++;
            if (dout !== LENGTH'(a)) $display("FAIL sweep_read a=%0d dout=%h expected=%h", a, dout, LENGTH'(a));
            else checks_passed++;
            // dout must hold between edges
            #3;
            checks_total++;
            if (dout !== LENGTH'(a)) $display("FAIL sweep_hold a=%0d dout=%h expected=%h", a, dout, LENGTH'(a));
            else checks_passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int wa;
        int ra;
        int d;
        bit r;
        for (int i = 0; i < 400; i++) begin
            wa = int'($urandom_range(0, DEPTH - 1));
            d  = int'($urandom_range(0, 4095));
            r  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) ra = wa;
            else ra = int'(written_q[$urandom_range(0, written_q.size() - 1)]);
            tick(r, wa, ra, d);
            checks_total++;
            if (dout !== exp_dout) $display("FAIL random cyc=%0d rst=%0b wa=%0d ra=%0d dout=%h expected=%h", i, r, wa, ra, dout, exp_dout);
            else checks_passed++;
        end
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i]  = '0;
            model_seen[i] = 1'b0;
        end
        rst        = 1'b1;
        write_addr = '0;
        read_addr  = '0;
        din        = '0;
        exp_dout   = '0;

        test_reset();
        test_same_addr();
        test_independent();
        test_reset_mid();
        test_back_to_back();
        test_random();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
